// File: rtl/serializador_diagonais.sv
`default_nettype none
// ============================================================================
//  Module   : serializador_diagonais
//  Purpose  : Captures a 27-pixel word and presents it one pixel per transfer
//             on a valid/ready stream, pixel 0 first. A new word may be
//             captured on the final transfer of the current one, so
//             back-to-back words stream without a bubble.
//  Ports    : clock       - rising-edge clock
//             reset       - synchronous, active-high
//             enable      - global stall (0 freezes all state, drops valid)
//             load        - request to capture in_bus
//             in_bus      - 27 pixels, pixel k at [k*DATA_WIDTH +: DATA_WIDTH]
//             busy        - a captured word is still being sent
//             out_data    - current pixel (holds last value while idle)
//             out_valid   - qualifies out_data
//             out_ready   - downstream accepts out_data
//             out_index   - index 0..26 of out_data (0 while idle)
//             out_last    - high with the pixel at index 26
//             drop_count  - (optional) saturating count of ignored loads
//  Options  : define SERIALIZADOR_DIAGONAIS_DROP_CNT_EN to add drop_count.
//  Revision : 1.0 - initial release
// ============================================================================
module serializador_diagonais #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    load,
    input  logic [27*DATA_WIDTH-1:0] in_bus,
    output logic                    busy,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4:0]              out_index,
    output logic                    out_last
`ifdef SERIALIZADOR_DIAGONAIS_DROP_CNT_EN
    ,
    output logic [7:0]              drop_count
`endif
);

    localparam logic [4:0] c_LAST_INDEX = 5'd26;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [4:0]                index_q, index_d;
    logic [27*DATA_WIDTH-1:0]  word_q, word_d;
    logic [DATA_WIDTH-1:0]     out_data_q, out_data_d;
    logic                      xfer;
    logic                      last_xfer;

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy      = (state_q == SEND);
    assign out_valid = busy && enable;
    assign out_index = busy ? index_q : 5'd0;
    assign out_last  = out_valid && (index_q == c_LAST_INDEX);
    assign out_data  = out_data_q;

    // out_valid already folds in enable, so a transfer needs nothing more.
    assign xfer      = out_valid && out_ready;
    assign last_xfer = xfer && (index_q == c_LAST_INDEX);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        word_d     = word_q;
        out_data_d = out_data_q;

        if (enable) begin
            case (state_q)
                IDLE: begin
                    if (load) begin
                        word_d  = in_bus;
                        index_d = 5'd0;
                        state_d = SEND;
                    end
                end
                SEND: begin
                    if (last_xfer) begin
                        index_d = 5'd0;
                        if (load) begin
                            // Chain the next word straight in: no idle cycle.
                            word_d = in_bus;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (xfer) begin
                        index_d = index_q + 5'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    index_d = 5'd0;
                end
            endcase
        end

        // The pixel register is preloaded with the pixel that will be shown
        // after the edge; while idle it keeps the last pixel presented.
        if (state_d == SEND) begin
            out_data_d = word_d[int'(index_d)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            index_q    <= 5'd0;
            word_q     <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            word_q     <= word_d;
            out_data_q <= out_data_d;
        end
    end

`ifdef SERIALIZADOR_DIAGONAIS_DROP_CNT_EN
    // ------------------------------------------------------------------
    // Ignored-load counter: a load seen while sending that is not on the
    // final transfer of the word. Stalled cycles never count.
    // ------------------------------------------------------------------
    logic [7:0] drop_count_q, drop_count_d;
    logic       drop;

    always_comb begin
        drop         = enable && (state_q == SEND) && load && !last_xfer;
        drop_count_d = drop_count_q;
        if (drop && (drop_count_q != 8'hFF)) begin
            drop_count_d = drop_count_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            drop_count_q <= 8'd0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serializador_diagonais.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serializador_diagonais
//  Purpose  : Self-checking bench for serializador_diagonais. A per-cycle
//             vector table covers reset, load, ready stalls and enable
//             stalls; hand-written sequences cover full words, chained
//             loads, ignored loads, long enable stalls and mid-word reset.
//             Every accepted pixel is compared against a scoreboard queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serializador_diagonais;

    localparam int DW = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic              enable;
    logic              load;
    logic [27*DW-1:0]  in_bus;
    logic              busy;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready;
    logic [4:0]        out_index;
    logic              out_last;
`ifdef SERIALIZADOR_DIAGONAIS_DROP_CNT_EN
    logic [7:0]        drop_count;
`endif

    serializador_diagonais #(.DATA_WIDTH(DW)) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .load      (load),
        .in_bus    (in_bus),
        .busy      (busy),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_last  (out_last)
`ifdef SERIALIZADOR_DIAGONAIS_DROP_CNT_EN
        ,
        .drop_count(drop_count)
`endif
    );

    always #5 clock = ~clock;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [DW-1:0] data;
        logic [4:0]    idx;
        logic          last;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [27*DW-1:0] pat(input int base);
        logic [27*DW-1:0] v;
        v = '0;
        for (int k = 0; k < 27; k++) v[k*DW +: DW] = DW'(base + k);
        return v;
    endfunction

    task automatic push_word(input int base);
        exp_t e;
        for (int k = 0; k < 27; k++) begin
            e.data = DW'(base + k);
            e.idx  = 5'(k);
            e.last = (k == 26);
            sb.push_back(e);
        end
    endtask

    // Monitor: mid-cycle sampling of transfers and of stall stability.
    exp_t          e_mon;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic [4:0]    prev_idx;
    logic          prev_last;

    always @(negedge clock) begin
        if (out_valid === 1'b1 && out_ready === 1'b1 && enable === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got pixel %0d at index %0d expected no transfer", out_data, out_index);
            end else begin
                e_mon = sb.pop_front();
                chk("sb_data",  32'(out_data),  32'(e_mon.data));
                chk("sb_index", 32'(out_index), 32'(e_mon.idx));
                chk("sb_last",  32'(out_last),  32'(e_mon.last));
            end
        end
        if (prev_stall && out_valid === 1'b1) begin
            chk("hold_data",  32'(out_data),  32'(prev_data));
            chk("hold_index", 32'(out_index), 32'(prev_idx));
            chk("hold_last",  32'(out_last),  32'(prev_last));
        end
        prev_stall = (out_valid === 1'b1 && out_ready === 1'b0);
        prev_data  = out_data;
        prev_idx   = out_index;
        prev_last  = out_last;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic b, input logic v,
                            input logic [DW-1:0] d, input logic [4:0] i, input logic l);
        chk({tag, "_busy"},  32'(busy),      32'(b));
        chk({tag, "_valid"}, 32'(out_valid), 32'(v));
        chk({tag, "_data"},  32'(out_data),  32'(d));
        chk({tag, "_index"}, 32'(out_index), 32'(i));
        chk({tag, "_last"},  32'(out_last),  32'(l));
    endtask

    // ------------------------------------------------------------------
    // Per-cycle vector table: inputs held across one edge, outputs then
    // checked with the same inputs still applied.
    // ------------------------------------------------------------------
    typedef struct {
        logic          rst, en, ld, rdy, push;
        logic          busy, valid;
        logic [DW-1:0] data;
        logic [4:0]    idx;
        logic          last;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        //            rst   en    ld    rdy   push  busy  valid data   idx    last
        tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 5'd0, 1'b0}; // reset beats load
        tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd1, 5'd0, 1'b0}; // load -> pixel 0
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd2, 5'd1, 1'b0}; // ready 1
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2, 5'd1, 1'b0}; // ready 0
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2, 5'd1, 1'b0}; // ready 0
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd3, 5'd2, 1'b0}; // ready 1
        tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd3, 5'd2, 1'b0}; // enable stall
        tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd4, 5'd3, 1'b0}; // load ignored
        tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 5'd0, 1'b0}; // reset mid-word
        tbl[9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 5'd0, 1'b0}; // stays idle

        reset     = 1'b1;
        enable    = 1'b1;
        load      = 1'b0;
        out_ready = 1'b0;
        in_bus    = pat(1);
        step();
        step();

        for (int i = 0; i < 10; i++) begin
            reset     = tbl[i].rst;
            enable    = tbl[i].en;
            load      = tbl[i].ld;
            out_ready = tbl[i].rdy;
            if (tbl[i].push) push_word(1);
            step();
            chk_outs($sformatf("vec%0d", i), tbl[i].busy, tbl[i].valid,
                     tbl[i].data, tbl[i].idx, tbl[i].last);
            if (tbl[i].rst) sb.delete();
        end
`ifdef SERIALIZADOR_DIAGONAIS_DROP_CNT_EN
        chk("vec_drop_after_reset", 32'(drop_count), 32'd0);
`endif
        reset = 1'b0;
        load  = 1'b0;

        // --- Full word, ready held high: 27 pixels in 27 cycles ---
        in_bus    = pat(1);
        out_ready = 1'b1;
        load      = 1'b1;
        push_word(1);
        step();
        load = 1'b0;
        chk_outs("full_first", 1'b1, 1'b1, 8'd1, 5'd0, 1'b0);
        for (int c = 0; c < 27; c++) step();
        chk_outs("full_done", 1'b0, 1'b0, 8'd27, 5'd0, 1'b0);
        chk("full_sb_empty", 32'(sb.size()), 32'd0);

        // --- Ignored loads at index 5 and 10, chained load at index 26 ---
        load = 1'b1;
        push_word(1);
        step();
        for (int c = 0; c < 27; c++) begin
            load   = (c == 5 || c == 10 || c == 26);
            in_bus = (c == 26) ? pat(100) : pat(200);
            if (c == 26) push_word(100);
            step();
        end
        load = 1'b0;
        chk_outs("chain_first", 1'b1, 1'b1, 8'd100, 5'd0, 1'b0);
`ifdef SERIALIZADOR_DIAGONAIS_DROP_CNT_EN
        chk("chain_drop_count", 32'(drop_count), 32'd2);
`endif
        for (int c = 0; c < 27; c++) step();
        chk_outs("chain_done", 1'b0, 1'b0, 8'd126, 5'd0, 1'b0);
        chk("chain_sb_empty", 32'(sb.size()), 32'd0);

        // --- Enable low for 5 cycles at index 12 ---
        in_bus = pat(1);
        load   = 1'b1;
        push_word(1);
        step();
        load = 1'b0;
        for (int c = 0; c < 12; c++) step();
        enable = 1'b0;
        for (int c = 0; c < 5; c++) begin
            load = (c == 2);
            step();
            chk_outs($sformatf("stall%0d", c), 1'b1, 1'b0, 8'd13, 5'd12, 1'b0);
        end
        load   = 1'b0;
        enable = 1'b1;
        #1;
        chk_outs("stall_resume", 1'b1, 1'b1, 8'd13, 5'd12, 1'b0);
        for (int c = 0; c < 15; c++) step();
        chk("stall_busy_done", 32'(busy), 32'd0);
        chk("stall_sb_empty", 32'(sb.size()), 32'd0);
`ifdef SERIALIZADOR_DIAGONAIS_DROP_CNT_EN
        chk("stall_drop_count", 32'(drop_count), 32'd2);
`endif

        // --- Reset at index 8, then a fresh word ---
        load = 1'b1;
        push_word(1);
        step();
        load = 1'b0;
        for (int c = 0; c < 8; c++) step();
        chk("abort_pre_index", 32'(out_index), 32'd8);
        out_ready = 1'b0;
        reset     = 1'b1;
        step();
        chk_outs("abort", 1'b0, 1'b0, 8'd0, 5'd0, 1'b0);
        sb.delete();
        reset     = 1'b0;
        out_ready = 1'b1;
        in_bus    = pat(50);
        load      = 1'b1;
        push_word(50);
        step();
        load = 1'b0;
        chk_outs("restart", 1'b1, 1'b1, 8'd50, 5'd0, 1'b0);
        for (int c = 0; c < 27; c++) step();
        chk("restart_busy_done", 32'(busy), 32'd0);
        chk("restart_sb_empty", 32'(sb.size()), 32'd0);

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serializador_diagonais.md
SERIALIZADOR_DIAGONAIS -- requirements
Module: serializador_diagonais

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the pixel width in bits.
REQ-002 The block SHALL have a single clock input, clock (1 bit); all state is updated on its rising edge.
REQ-003 The block SHALL have reset (input, 1 bit); reset is synchronous and active-high.
REQ-004 The block SHALL have enable (input, 1 bit): a global stall, active-high.
REQ-005 The block SHALL have load (input, 1 bit): a request to capture a new 27-pixel word.
REQ-006 The block SHALL have in_bus (input, 27*DATA_WIDTH bits): pixel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH], for k = 0..26.
REQ-007 The block SHALL have busy (output, 1 bit): high while a captured word is not fully sent.
REQ-008 The block SHALL have out_data (output, DATA_WIDTH bits): the current pixel.
REQ-009 The block SHALL have out_valid (output, 1 bit), qualifying out_data.
REQ-010 The block SHALL have out_ready (input, 1 bit): the downstream accepts out_data.
REQ-011 The block SHALL have out_index (output, 5 bits): the index k, 0..26, of out_data.
REQ-012 The block SHALL have out_last (output, 1 bit): high when out_index = 26 and out_valid = 1.

Function
REQ-013 The block SHALL implement a two-state FSM with states IDLE and SEND.
REQ-014 In IDLE with enable=1 and load=1, the block SHALL register in_bus, set index=0 and move to SEND; out_valid SHALL be 1 with out_data=pixel 0 in the next cycle, giving one cycle of latency.
REQ-015 In SEND, out_valid SHALL be 1 and out_data SHALL equal the registered pixel[index].
REQ-016 A transfer SHALL occur on a cycle where out_valid=1, out_ready=1 and enable=1; only a transfer advances index by 1.
REQ-017 While out_valid=1 and out_ready=0, out_data, out_index and out_last SHALL remain stable.
REQ-018 On the transfer at index 26, the block SHALL return to IDLE with index=0, unless load=1 on the same cycle.
REQ-019 If load=1 on the index-26 transfer, the block SHALL capture in_bus, stay in SEND with index=0, and leave no bubble, so 27 pixels take 27 cycles when out_ready is held high.
REQ-020 A load in SEND on any cycle other than the index-26 transfer SHALL be ignored, and the registered word SHALL be unchanged.
REQ-021 With enable=0, state, index and the registered word SHALL hold, out_valid SHALL be 0, and load SHALL be ignored and not counted.
REQ-022 busy SHALL be 1 exactly when the state is SEND.
REQ-023 In IDLE, out_valid, out_last and out_index SHALL be 0, and out_data SHALL hold its last value.

Reset
REQ-024 While reset=1 at a rising edge, the block SHALL go to IDLE with index=0, the registered word at 0, out_data=0, out_valid=0, out_last=0 and busy=0; reset has priority over load and enable.
REQ-025 A reset during SEND SHALL abort the word; no further pixel of it SHALL be presented.

Configuration
REQ-026 When macro SERIALIZADOR_DIAGONAIS_DROP_CNT_EN is defined, the block SHALL add output drop_count (8 bits), reset to 0.
REQ-027 With the macro defined, drop_count SHALL increment on each load ignored per REQ-020, and SHALL saturate at 255.
REQ-028 Without the macro, the drop_count port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 DATA_WIDTH=8, pixel k = k+1, one load, out_ready=1 -> out_data 1..27 on 27 consecutive cycles, out_index 0..26, out_last only on 27, then busy=0.
REQ-030 out_ready toggles 1,0,0,1 during SEND -> out_data held on the stalled cycles, with no skipped or repeated index.
REQ-031 A second load (pixel k = 100+k) asserted on the index-26 transfer -> the next cycle shows out_data=100 at out_index=0, with no idle cycle.
REQ-032 load pulsed at index 5 and index 10 -> sequence unaffected; with the macro defined, drop_count=2.
REQ-033 enable=0 for 5 cycles at index 12 -> out_valid=0 during the stall, then resumes at index 12 with the same data.
REQ-034 reset=1 at index 8 -> next cycle busy=0, out_valid=0, out_data=0; a following load restarts at index 0.
